// File: rtl/multichannel_lockin_demod_pkg.sv
// Shared types and helpers for the multichannel lock-in demodulator.
// Holds the sweep state encoding and a width-generic signed saturator.
package lockin_pkg;

  typedef enum logic [1:0] {IDLE, MULT, FILT, DONE} state_t;

  localparam int SAMPLE_W = 24;
  localparam logic signed [63:0] SAMPLE_MAX = (64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1;
  localparam logic signed [63:0] SAMPLE_MIN = -(64'sd1 <<< (SAMPLE_W - 1));

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/multichannel_lockin_demod_frac_mul_sat.sv
// Registered signed Q1.(W-1) x Q1.(W-1) multiply, floor-shifted back to W bits
// and saturated (only full-scale negative squared can overflow).
module frac_mul_sat
  import lockin_pkg::*;
#(
  parameter int W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);

  logic signed [2*W-1:0] prod;
  logic signed [63:0]    scaled;

  assign prod   = a * b;
  assign scaled = 64'(prod) >>> (W - 1);

  always_ff @(posedge clk) begin
    if (reset)   p <= '0;
    else if (en) p <= W'(sat_w(scaled, W));
  end

endmodule

// File: rtl/multichannel_lockin_demod.sv
// Lock-in demodulator: one shared I/Q multiplier pair swept over N_CH channels,
// per-channel first-order IIR smoothing, decimated output with overrun flag.
module multichannel_lockin_demod
  import lockin_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int W         = 24,
  parameter int LPF_SHIFT = 4,
  parameter int DECIM     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_i,
  input  logic [N_CH*W-1:0] sig_i,
  input  logic [W-1:0]      sin_i,
  input  logic [W-1:0]      cos_i,
  input  logic              clear_overrun_i,
  output logic [N_CH*W-1:0] i_o,
  output logic [N_CH*W-1:0] q_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic [31:0]       sample_count_o
);

  localparam int KW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = W + LPF_SHIFT + 1;

  state_t state, state_nx;
  logic [KW-1:0]         k;
  logic [DW-1:0]         dcnt;
  logic [N_CH*W-1:0]     sig_r;
  logic signed [W-1:0]   sin_r, cos_r;
  logic signed [W-1:0]   x_k, pi, pq;
  logic signed [AW-1:0]  acc_i [N_CH];
  logic signed [AW-1:0]  acc_q [N_CH];
  logic signed [AW-1:0]  acc_ki, acc_kq;
  logic signed [AW+1:0]  nx_i, nx_q;
  logic [N_CH*W-1:0]     y_i, y_q;
  logic                  last_ch;

  assign last_ch = (int'(k) == N_CH - 1);
  assign busy_o  = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick_i) state_nx = MULT;
      MULT:    state_nx = FILT;
      FILT:    state_nx = last_ch ? DONE : MULT;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      sig_r <= '0;
      sin_r <= '0;
      cos_r <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && tick_i) begin
        sig_r <= sig_i;
        sin_r <= sin_i;
        cos_r <= cos_i;
        k     <= '0;
      end else if (state == FILT && !last_ch) begin
        k <= k + 1'b1;
      end
    end
  end

  // Set beats clear so a simultaneous overrun is never lost.
  always_ff @(posedge clk) begin
    if (reset)                         overrun_o <= 1'b0;
    else if (tick_i && state != IDLE)  overrun_o <= 1'b1;
    else if (clear_overrun_i)          overrun_o <= 1'b0;
  end

  always_comb begin
    x_k    = '0;
    acc_ki = '0;
    acc_kq = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(k) == c) begin
        x_k    = sig_r[c*W +: W];
        acc_ki = acc_i[c];
        acc_kq = acc_q[c];
      end
    end
  end

  frac_mul_sat #(.W(W)) u_mul_i (
    .clk(clk), .reset(reset), .en(state == MULT), .a(x_k), .b(cos_r), .p(pi)
  );
  frac_mul_sat #(.W(W)) u_mul_q (
    .clk(clk), .reset(reset), .en(state == MULT), .a(x_k), .b(sin_r), .p(pq)
  );

  // acc += p - acc/2^S; steady state settles at p*2^S, hence the S+1 headroom bits.
  assign nx_i = (AW+2)'(acc_ki) + (AW+2)'(pi) - (AW+2)'(acc_ki >>> LPF_SHIFT);
  assign nx_q = (AW+2)'(acc_kq) + (AW+2)'(pq) - (AW+2)'(acc_kq >>> LPF_SHIFT);

  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (reset) begin
        acc_i[c] <= '0;
        acc_q[c] <= '0;
      end else if (state == FILT && int'(k) == c) begin
        acc_i[c] <= AW'(nx_i);
        acc_q[c] <= AW'(nx_q);
      end
    end
  end

  always_comb begin
    y_i = '0;
    y_q = '0;
    for (int c = 0; c < N_CH; c++) begin
      y_i[c*W +: W] = W'(sat_w(64'(acc_i[c] >>> LPF_SHIFT), W));
      y_q[c*W +: W] = W'(sat_w(64'(acc_q[c] >>> LPF_SHIFT), W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_o            <= '0;
      q_o            <= '0;
      done_o         <= 1'b0;
      sample_count_o <= '0;
      dcnt           <= '0;
    end else begin
      done_o <= 1'b0;
      if (state == DONE) begin
        if (int'(dcnt) == DECIM - 1) begin
          i_o            <= y_i;
          q_o            <= y_q;
          done_o         <= 1'b1;
          sample_count_o <= sample_count_o + 32'd1;
          dcnt           <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multichannel_lockin_demod.sv
// Directed bench: four demodulator instances cover basic I/Q, saturation,
// reset mid-sweep, IIR step response, decimation and overrun handling.
module tb_multichannel_lockin_demod;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr = 1'b0;
  logic [3:0] tk = '0;
  logic [95:0] sig = '0;
  logic [23:0] sn = '0, cs = '0;
  logic [3:0] dn, bz, ov;

  logic [47:0] ia, qa;
  logic [23:0] ib, qb, ic, qc;
  logic [95:0] id, qd;
  logic [31:0] cnta, cntb, cntc, cntd;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  multichannel_lockin_demod #(.N_CH(2), .W(24), .LPF_SHIFT(0), .DECIM(1)) u_a (
    .clk(clk), .reset(reset), .tick_i(tk[0]), .sig_i(sig[47:0]), .sin_i(sn), .cos_i(cs),
    .clear_overrun_i(clr), .i_o(ia), .q_o(qa), .done_o(dn[0]), .busy_o(bz[0]),
    .overrun_o(ov[0]), .sample_count_o(cnta));
  multichannel_lockin_demod #(.N_CH(1), .W(24), .LPF_SHIFT(2), .DECIM(1)) u_b (
    .clk(clk), .reset(reset), .tick_i(tk[1]), .sig_i(sig[23:0]), .sin_i(sn), .cos_i(cs),
    .clear_overrun_i(clr), .i_o(ib), .q_o(qb), .done_o(dn[1]), .busy_o(bz[1]),
    .overrun_o(ov[1]), .sample_count_o(cntb));
  multichannel_lockin_demod #(.N_CH(1), .W(24), .LPF_SHIFT(0), .DECIM(4)) u_c (
    .clk(clk), .reset(reset), .tick_i(tk[2]), .sig_i(sig[23:0]), .sin_i(sn), .cos_i(cs),
    .clear_overrun_i(clr), .i_o(ic), .q_o(qc), .done_o(dn[2]), .busy_o(bz[2]),
    .overrun_o(ov[2]), .sample_count_o(cntc));
  multichannel_lockin_demod #(.N_CH(4), .W(24), .LPF_SHIFT(4), .DECIM(1)) u_d (
    .clk(clk), .reset(reset), .tick_i(tk[3]), .sig_i(sig), .sin_i(sn), .cos_i(cs),
    .clear_overrun_i(clr), .i_o(id), .q_o(qd), .done_o(dn[3]), .busy_o(bz[3]),
    .overrun_o(ov[3]), .sample_count_o(cntd));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One tick into instance u, then watch done for ncyc edges after the tick edge.
  task automatic fire(input int u, input int ncyc, output int lat, output int nd);
    @(posedge clk); #1 tk[u] = 1'b1;
    @(posedge clk); #1 tk[u] = 1'b0;
    lat = -1;
    nd  = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk); #1;
      if (dn[u]) begin
        nd++;
        if (lat < 0) lat = n;
      end
    end
  endtask

  function automatic longint s24(input logic [23:0] v);
    return longint'($signed(v));
  endfunction

  initial begin
    int lat, nd, tot;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_i", ia, 0);
    chk("rst_q", qa, 0);
    chk("rst_done", dn[0], 0);
    chk("rst_busy", bz[0], 0);
    chk("rst_ovr", ov[0], 0);
    chk("rst_cnt", cnta, 0);

    // basic I/Q on two channels
    sig[23:0] = 24'd4194304; sig[47:24] = -24'sd4194304; cs = 24'd8388607; sn = '0;
    fire(0, 8, lat, nd);
    chk("a_lat", lat, 5);
    chk("a_ndone", nd, 1);
    chk("a_i0", s24(ia[23:0]), 4194303);
    chk("a_i1", s24(ia[47:24]), -4194304);
    chk("a_q", qa, 0);
    chk("a_cnt", cnta, 1);
    chk("a_busy_idle", bz[0], 0);

    // saturation of full-scale negative squared
    sig[23:0] = -24'sd8388608; sig[47:24] = '0; cs = -24'sd8388608; sn = 24'd8388607;
    fire(0, 8, lat, nd);
    chk("sat_i0", s24(ia[23:0]), 8388607);
    chk("sat_q0", s24(qa[23:0]), -8388607);
    chk("sat_i1", s24(ia[47:24]), 0);
    chk("sat_cnt", cnta, 2);

    // reset while in FILT(1): edges 1..3 bring it to FILT(1)
    sig[23:0] = 24'd4194304; sig[47:24] = -24'sd4194304; cs = 24'd8388607; sn = '0;
    @(posedge clk); #1 tk[0] = 1'b1;
    @(posedge clk); #1 tk[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy", bz[0], 0);
    chk("mid_i", ia, 0);
    chk("mid_q", qa, 0);
    chk("mid_cnt", cnta, 0);
    chk("mid_done", dn[0], 0);
    reset = 1'b0;
    nd = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (dn[0]) nd++;
    end
    chk("mid_no_done", nd, 0);
    sig[23:0] = 24'd2097152; sig[47:24] = '0; cs = 24'd8388607; sn = 24'd4194304;
    fire(0, 8, lat, nd);
    chk("mid_lat", lat, 5);
    chk("mid_i0", s24(ia[23:0]), 2097151);
    chk("mid_q0", s24(qa[23:0]), 1048576);
    chk("mid_cnt2", cnta, 1);

    // IIR step, shift 2, constant product 1024
    sig[23:0] = 24'd2048; cs = 24'd4194304; sn = '0;
    fire(1, 6, lat, nd);
    chk("iir_lat", lat, 3);
    chk("iir_y1", s24(ib), 256);
    fire(1, 6, lat, nd);
    chk("iir_y2", s24(ib), 448);
    fire(1, 6, lat, nd);
    chk("iir_y3", s24(ib), 592);
    chk("iir_q", qb, 0);

    // decimation by 4 over 8 ticks
    sig[23:0] = 24'd4194304; cs = 24'd8388607; sn = '0;
    tot = 0;
    for (int t = 0; t < 8; t++) begin
      fire(2, 8, lat, nd);
      tot += nd;
      if (t == 2) chk("dec_hold_i", ic, 0);
      if (t == 3) chk("dec_first_i", s24(ic), 4194303);
    end
    chk("dec_ndone", tot, 2);
    chk("dec_cnt", cntc, 2);

    // overrun: second tick 3 cycles after the first
    sig = '0; sig[23:0] = 24'd4194304; cs = 24'd8388607; sn = '0;
    @(posedge clk); #1 tk[3] = 1'b1;
    @(posedge clk); #1 tk[3] = 1'b0;
    repeat (2) @(posedge clk);
    #1 tk[3] = 1'b1;
    @(posedge clk); #1 tk[3] = 1'b0;
    lat = -1; nd = 0;
    for (int n = 4; n <= 20; n++) begin
      @(posedge clk); #1;
      if (dn[3]) begin
        nd++;
        if (lat < 0) lat = n;
      end
    end
    chk("ovr_ndone", nd, 1);
    chk("ovr_lat", lat, 9);
    chk("ovr_flag", ov[3], 1);
    chk("ovr_i0", s24(id[23:0]), 262143);
    chk("ovr_cnt", cntd, 1);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("ovr_clear", ov[3], 0);
    clr = 1'b0;

    // overrun set and clear in the same cycle: set wins
    @(posedge clk); #1 tk[3] = 1'b1;
    @(posedge clk); #1 tk[3] = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    chk("ovr_set_wins", ov[3], 1);
    tk[3] = 1'b0;
    @(posedge clk); #1;
    chk("ovr_clear2", ov[3], 0);
    clr = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("ovr_idle", bz[3], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multichannel_lockin_demod.md
Name: multichannel_lockin_demod

Overview:
- Parametrised lock-in demodulator for N_CH channels (QPD sum/diff, extra quadrants, auxiliary photodiodes) sharing one sin/cos reference.
- Time-multiplexes one I/Q multiplier pair across channels, then low-passes each product with a per-channel first-order IIR and decimates the output.
- Sits after the input filters and Hilbert stage; its outputs feed the AXI output registers.
- Adds over the fixed two-channel demodulator: arbitrary channel count, IIR smoothing, output decimation and overrun detection.

Parameters:
- N_CH, 4, number of input channels (1..16)
- W, 24, sample, reference and output width, signed Q1.(W-1)
- LPF_SHIFT, 4, IIR smoothing shift; 0 = filter bypass
- DECIM, 1, output decimation ratio (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- tick_i  in  1  one-cycle strobe: new inputs valid
- sig_i  in  N_CH*W  packed signed samples, channel k at [k*W +: W]
- sin_i  in  W  signed reference, sine
- cos_i  in  W  signed reference, cosine
- clear_overrun_i  in  1  clears overrun_o
- i_o  out  N_CH*W  packed filtered in-phase outputs
- q_o  out  N_CH*W  packed filtered quadrature outputs
- done_o  out  1  one-cycle strobe: i_o/q_o updated
- busy_o  out  1  high while not IDLE
- overrun_o  out  1  sticky: tick_i arrived while busy
- sample_count_o  out  32  count of emitted output sets

Behaviour:
- Reset values: i_o, q_o, done_o, busy_o, overrun_o, sample_count_o, all accumulators and the decimation counter are 0; FSM goes to IDLE. Reset mid-operation aborts the sweep; no done_o is emitted.
- FSM: IDLE -> MULT(k) -> FILT(k) -> MULT(k+1) ... -> FILT(N_CH-1) -> DONE -> IDLE.
- IDLE: on tick_i, latch sig_i, sin_i and cos_i into internal registers, set k=0 and go to MULT(0).
- MULT(k): register pi = sat((x_k*cos) >>> (W-1)) and pq = sat((x_k*sin) >>> (W-1)).
  - Full 2W-bit signed product; arithmetic shift rounds toward -inf.
  - Saturate to [-2^(W-1), 2^(W-1)-1]; only (-2^(W-1))^2 overflows.
- FILT(k): for each of I and Q, acc_k <= acc_k + p - (acc_k >>> LPF_SHIFT).
  - Accumulator width is W+LPF_SHIFT+1.
  - Filter output is y_k = acc_k >>> LPF_SHIFT, saturated to W bits.
  - With LPF_SHIFT=0, y_k = p exactly.
- DONE: increment the decimation counter.
  - When it reaches DECIM-1: load all y_k into i_o/q_o in the same cycle, pulse done_o high for this one cycle, increment sample_count_o (wraps at 2^32), reset the counter to 0.
  - Otherwise outputs hold and done_o stays low.
- Latency: done_o is asserted exactly 2*N_CH+1 cycles after the clock edge that samples tick_i. Throughput: one tick per 2*N_CH+2 cycles.
- busy_o is high in every state except IDLE.
- A tick_i seen in any non-IDLE state is dropped and sets overrun_o. A tick_i in IDLE immediately after DONE is accepted.
- If clear_overrun_i and an overrun event occur in the same cycle, the set wins.
- Accumulators persist across sweeps; only reset clears them.
- Outputs change only in DONE.

Decomposition:
- Package lockin_pkg:
  - state_t enum {IDLE, MULT, FILT, DONE}
  - function sat_w (generic signed saturation to W)
  - constants SAMPLE_MAX and SAMPLE_MIN derived from W
- Sub-module frac_mul_sat: registered signed W x W fractional multiply with saturation; instantiated twice (I and Q).
- Accumulators are an unpacked array indexed by k, one per channel per quadrature. The FSM and channel counter live in the top.

Test Plan:
- N_CH=2, W=24, LPF_SHIFT=0, DECIM=1; sig0=4194304, sig1=-4194304, cos=8388607, sin=0; one tick -> i_o ch0=4194303, ch1=-4194304, q_o all 0; done_o exactly 5 cycles after the tick edge; sample_count_o=1.
- Saturation: sig0=-8388608, cos=-8388608, sin=8388607 -> i_o ch0=8388607, q_o ch0=-8388607.
- IIR step: LPF_SHIFT=2, N_CH=1, product constant 1024 (sig=1024, cos=8388607 gives 1023; use sig=2048, cos=4194304 -> p=1024); three ticks -> i_o = 256, 448, 592.
- Decimation: DECIM=4, 8 ticks spaced 10 cycles apart -> done_o exactly twice (after ticks 4 and 8); sample_count_o=2.
- Overrun: N_CH=4, second tick 3 cycles after the first -> second tick ignored, overrun_o=1, exactly one done_o; assert clear_overrun_i -> overrun_o=0 the next cycle.
- Reset mid-sweep: assert reset in FILT(1) -> next cycle all outputs and busy_o are 0, no done_o; a following tick completes normally from zeroed accumulators.
